// File: rtl/video_sprite_motion.sv
// Per-frame sprite origin controller: applies a signed velocity once per frame
// during vertical blanking, bouncing or wrapping at the display edges.
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif

module video_sprite_motion #(
  parameter int H_DISPLAY    = 640,
  parameter int V_DISPLAY    = 480,
  parameter int SPRITE_HSIZE = 32,
  parameter int SPRITE_VSIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic [`H_SIZE-1:0] xx,
  input  logic [`V_SIZE-1:0] yy,
  output logic [31:0]       x0,
  output logic [31:0]       y0,
  output logic              step,
  output logic              hit
);
  localparam int HW = `H_SIZE;
  localparam int VW = `V_SIZE;
  localparam int AW = ((HW > VW) ? HW : VW) + 2;

  localparam logic signed [AW-1:0] XDISP = AW'(H_DISPLAY);
  localparam logic signed [AW-1:0] YDISP = AW'(V_DISPLAY);
  localparam logic signed [AW-1:0] XMAX  = AW'(H_DISPLAY - SPRITE_HSIZE);
  localparam logic signed [AW-1:0] YMAX  = AW'(V_DISPLAY - SPRITE_VSIZE);

  typedef enum logic [1:0] {IDLE, WAIT, CALC} state_t;

  state_t         state_q, state_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic [23:0]    vel_q, vel_d;
  logic [7:0]     div_cnt_q, div_cnt_d;
  logic [HW-1:0]  x_q, x_d;
  logic [VW-1:0]  y_q, y_d;

  logic                 tick;
  logic signed [AW-1:0] nx, ny;
  logic [7:0]           ndx, ndy;
  logic                 hx, hy;
  logic                 unused_bits;

  // One axis of motion; the window is widened so the raw sum can go negative
  // or past the display edge before it is clamped or wrapped.
  function automatic void axis_step(
    input  logic [AW-1:0]        pos,
    input  logic [7:0]           v,
    input  logic                 wrap,
    input  logic signed [AW-1:0] disp,
    input  logic signed [AW-1:0] pmax,
    output logic signed [AW-1:0] np,
    output logic [7:0]           nv,
    output logic                 h
  );
    logic signed [AW-1:0] sum;
    logic [7:0]           vneg;
    sum  = $signed(pos) + $signed({{(AW-8){v[7]}}, v});
    vneg = (v == 8'h80) ? 8'h7F : 8'(-v);
    np   = sum;
    nv   = v;
    h    = 1'b0;
    if (wrap) begin
      if (sum < 0) begin
        np = sum + disp;
        h  = 1'b1;
      end else if (sum >= disp) begin
        np = sum - disp;
        h  = 1'b1;
      end
    end else begin
      if (sum < 0) begin
        np = '0;
        nv = vneg;
        h  = 1'b1;
      end else if (sum > pmax) begin
        np = pmax;
        nv = vneg;
        h  = 1'b1;
      end
    end
  endfunction

  assign tick = (xx == '0) && (yy == VW'(V_DISPLAY));

  always_comb begin
    axis_step(AW'(x_q), vel_q[7:0],  ctrl_q[1], XDISP, XMAX, nx, ndx, hx);
    axis_step(AW'(y_q), vel_q[15:8], ctrl_q[1], YDISP, YMAX, ny, ndy, hy);
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    vel_d     = vel_q;
    div_cnt_d = div_cnt_q;
    x_d       = x_q;
    y_d       = y_q;

    case (state_q)
      IDLE: if (ctrl_q[0]) state_d = WAIT;
      WAIT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (tick) begin
          if (div_cnt_q == vel_q[23:16]) begin
            div_cnt_d = '0;
            state_d   = CALC;
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end
      end
      CALC: begin
        state_d      = WAIT;
        x_d          = nx[HW-1:0];
        y_d          = ny[VW-1:0];
        vel_d[7:0]   = ndx;
        vel_d[15:8]  = ndy;
      end
      default: state_d = IDLE;
    endcase

    // Host writes land after the motion update so they win in the CALC cycle.
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: ctrl_d = cfg_wdata[1:0];
        2'd1: x_d    = cfg_wdata[HW-1:0];
        2'd2: y_d    = cfg_wdata[VW-1:0];
        2'd3: begin
          vel_d = cfg_wdata[23:0];
          if (cfg_wdata[23:16] != vel_q[23:16]) div_cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      vel_q     <= '0;
      div_cnt_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      vel_q     <= vel_d;
      div_cnt_q <= div_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign x0   = {{(32-HW){1'b0}}, x_q};
  assign y0   = {{(32-VW){1'b0}}, y_q};
  assign step = (state_q == CALC) && rst;
  assign hit  = step && (hx || hy);

  assign unused_bits = ^{cfg_wdata[31:24], nx[AW-1:HW], ny[AW-1:VW]};
endmodule

// File: tb/tb_video_sprite_motion.sv
// Directed bench for video_sprite_motion: frame ticks are driven directly on xx/yy.
module tb_video_sprite_motion;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [9:0]  xx;
  logic [9:0]  yy;
  logic [31:0] x0;
  logic [31:0] y0;
  logic        step;
  logic        hit;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic st_tick, st, ht;

  video_sprite_motion #(
    .H_DISPLAY(640),
    .V_DISPLAY(480),
    .SPRITE_HSIZE(32),
    .SPRITE_VSIZE(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .xx(xx),
    .yy(yy),
    .x0(x0),
    .y0(y0),
    .step(step),
    .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Two idle cycles, one tick cycle, then the following cycle (optionally with a
  // concurrent cfg write or reset), ending #1 after the edge that closes it.
  task automatic frame(input logic dw, input logic [1:0] a, input logic [31:0] d,
                       input logic rs, output logic s_tick, output logic s, output logic h);
    repeat (2) begin @(posedge clk); #1; end
    xx = 10'd0; yy = 10'd480;
    #1 s_tick = step;
    @(posedge clk); #1;
    xx = 10'd5; yy = 10'd0;
    if (dw) begin cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; end
    if (rs) rst = 1'b0;
    #1 s = step; h = hit;
    @(posedge clk); #1;
    cfg_we = 1'b0; rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    xx = 10'd5; yy = 10'd0;

    // Reset with writes active
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = 2'(i); cfg_wdata = 32'h0001_0123 + 32'(i);
      @(posedge clk); #1;
    end
    cfg_we = 1'b0; rst = 1'b1;
    chk("rst_x0", x0, 0);
    chk("rst_y0", y0, 0);
    chk("rst_step", {31'd0, step}, 0);
    chk("rst_hit", {31'd0, hit}, 0);
    frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
    chk("rst_nomove_step", {31'd0, st}, 0);
    chk("rst_nomove_x0", x0, 0);

    // Linear motion
    wr(2'd1, 32'd100);
    wr(2'd2, 32'd50);
    wr(2'd3, 32'h0000_FE03);
    wr(2'd0, 32'd1);
    for (int f = 1; f <= 3; f++) begin
      frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
      chk("lin_step_tick", {31'd0, st_tick}, 0);
      chk("lin_step", {31'd0, st}, 1);
      chk("lin_hit", {31'd0, ht}, 0);
      chk("lin_x0", x0, 32'(100 + 3 * f));
      chk("lin_y0", y0, 32'(50 - 2 * f));
      chk("lin_step_after", {31'd0, step}, 0);
    end

    // Bounce at right edge
    wr(2'd1, 32'd606);
    wr(2'd3, 32'h0000_0005);
    frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
    chk("bnc_x0", x0, 608);
    chk("bnc_hit", {31'd0, ht}, 1);
    chk("bnc_step", {31'd0, st}, 1);
    frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
    chk("bnc2_x0", x0, 603);
    chk("bnc2_hit", {31'd0, ht}, 0);
    chk("bnc2_y0", y0, 44);

    // Wrap mode
    wr(2'd0, 32'd3);
    wr(2'd2, 32'd2);
    wr(2'd3, 32'h0000_FC00);
    frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
    chk("wrp_y0", y0, 478);
    chk("wrp_yhit", {31'd0, ht}, 1);
    chk("wrp_x0_hold", x0, 603);
    wr(2'd1, 32'd638);
    wr(2'd3, 32'h0000_0004);
    frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
    chk("wrp_x0", x0, 2);
    chk("wrp_xhit", {31'd0, ht}, 1);
    chk("wrp_y0_hold", y0, 478);

    // Zero velocity still steps
    wr(2'd3, 32'h0000_0000);
    frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
    chk("zero_step", {31'd0, st}, 1);
    chk("zero_hit", {31'd0, ht}, 0);
    chk("zero_x0", x0, 2);
    chk("zero_y0", y0, 478);

    // Frame divider
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd100);
    wr(2'd3, 32'h0002_0001);
    for (int f = 1; f <= 9; f++) begin
      frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
      chk("div_step", {31'd0, st}, (f % 3 == 0) ? 32'd1 : 32'd0);
      chk("div_x0", x0, 32'(f / 3));
    end

    // XPOS write in the CALC cycle wins for x only
    wr(2'd3, 32'h0000_0107);
    frame(1'b1, 2'd1, 32'd200, 1'b0, st_tick, st, ht);
    chk("col_step", {31'd0, st}, 1);
    chk("col_x0", x0, 200);
    chk("col_y0", y0, 101);

    // Disable in CALC: that step completes, then motion freezes
    frame(1'b1, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
    chk("dis_step", {31'd0, st}, 1);
    chk("dis_x0", x0, 207);
    chk("dis_y0", y0, 102);
    for (int f = 0; f < 5; f++) begin
      frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
      chk("frz_step", {31'd0, st}, 0);
      chk("frz_x0", x0, 207);
      chk("frz_y0", y0, 102);
    end

    // Reset asserted during CALC
    wr(2'd0, 32'd1);
    frame(1'b0, 2'd0, 32'd0, 1'b1, st_tick, st, ht);
    chk("rcalc_step", {31'd0, st}, 0);
    chk("rcalc_x0", x0, 0);
    chk("rcalc_y0", y0, 0);
    frame(1'b0, 2'd0, 32'd0, 1'b0, st_tick, st, ht);
    chk("rcalc_idle_step", {31'd0, st}, 0);
    chk("rcalc_idle_x0", x0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
